multi_debouncer: RTL and testbench
==================================

Name: multi_debouncer

Overview:
- Parametrised N-channel push-button debouncer; successor to the single-channel debouncer.
- Per channel: 2-FF synchroniser, settle counter, debounced level, one-cycle press/release pulses.
- Sits between board buttons and control logic (mode FSMs, up/down counters), so consumers do not need their own edge detectors.

Parameters:
- CHANNELS, 4, number of independent button inputs (1..32)
- CNT_W, 21, settle counter width; input must be stable SETTLE = 2^(CNT_W-1) cycles before it is accepted
- ACTIVE_LOW, 1, 1 = raw inputs are pressed-low (pull-up buttons); 0 = pressed-high
- LONG_CNT, 50000000, cycles btn_level must stay 1 before long_pulse fires (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, reset is synchronous and active-low
- btn_in  in  CHANNELS  raw asynchronous button inputs
- btn_level  out  CHANNELS  debounced pressed state, 1 = pressed, regardless of ACTIVE_LOW
- press_pulse  out  CHANNELS  one-cycle pulse on each debounced 0->1 transition
- release_pulse  out  CHANNELS  one-cycle pulse on each debounced 1->0 transition
- any_pressed  out  1  registered OR of btn_level
- long_pulse  out  CHANNELS  one-cycle long-press pulse; constant 0 without the macro

Behaviour:
- Reset (rst==0 at a clk edge):
  - Sync FFs load the idle input level (1 if ACTIVE_LOW, else 0).
  - Settle counters and hold counters clear to 0.
  - All outputs are 0 from the next cycle.
  - No pulse is generated by reset release itself.
- Per channel:
  - s1 <= btn_in, normalised to active-high by inverting when ACTIVE_LOW=1; s2 <= s1.
  - Settle counter:
    - cleared when s1 != s2;
    - otherwise incremented while MSB == 0;
    - saturates once MSB == 1 (no wrap).
  - While the counter MSB == 1, the level register loads s2; otherwise it holds.
- Latency: a clean input change at edge t appears on btn_level at edge t + SETTLE + 3, exactly.
- Bounce: any input toggle restarts settling. A glitch shorter than SETTLE cycles never changes btn_level and never produces a pulse.
- Pulses:
  - Registered alongside the level register: press_pulse = level_next & ~level, release_pulse = ~level_next & level.
  - Each pulse is high exactly in the first cycle the new btn_level value is visible.
  - At most one pulse per channel per cycle.
- any_pressed: registered from level_next, so it is coincident with btn_level.
- Channels are fully independent. Simultaneous events on several channels produce simultaneous pulses.
- Reset mid-settle:
  - Counter is discarded and outputs drop to 0 immediately (no release_pulse).
  - After rst returns high, a held button re-debounces: press_pulse fires SETTLE+3 cycles after reset release.

Optional Feature:
- Macro: DEBOUNCE_LONG_PRESS_EN.
- Defined:
  - Per-channel hold counter of width $clog2(LONG_CNT+1), cleared whenever btn_level==0.
  - Increments while btn_level==1 and saturates at LONG_CNT.
  - long_pulse fires for one cycle when the count reaches LONG_CNT, once per press.
  - Releasing before LONG_CNT yields no long_pulse.
- Undefined: no hold counters are built; long_pulse is tied to 0; the port list is unchanged.

Decomposition:
- Package debounce_pkg:
  - IDLE_LEVEL function of ACTIVE_LOW
  - settle-counter width helper
  - hold-counter width function ($clog2 based)
  - default CNT_W / LONG_CNT constants
- Sub-module debounce_chan:
  - one channel (sync, settle counter, level, pulses, optional hold counter);
  - instantiated CHANNELS times in a generate loop.
- Top module: generate loop plus the any_pressed OR register.

Test Plan (CHANNELS=4, CNT_W=4 so SETTLE=8, ACTIVE_LOW=1, LONG_CNT=20):
1. Reset 3 cycles, btn_in=4'hF held for 50 cycles -> all outputs stay 0, no pulses.
2. btn_in[0] falls to 0 at edge t and is held -> btn_level[0]=1 and press_pulse[0]=1 (single cycle) at t+11; any_pressed=1 at t+11. Then btn_in[0] rises at edge u -> release_pulse[0] at u+11, btn_level[0]=0.
3. btn_in[1] toggles every 5 cycles for 40 cycles, then stays 0 -> no pulse during bouncing; press_pulse[1] exactly 11 cycles after the last edge. A 1-cycle glitch on btn_in[2] -> no change at all.
4. btn_in[2] and btn_in[3] fall in the same cycle -> press_pulse[2] and [3] are coincident. Release of ch2 only -> release_pulse[2] only; btn_level[3] and any_pressed stay 1.
5. Press ch0, assert rst low for 1 cycle at settle count 5 while still held -> outputs 0; press_pulse[0] fires 11 cycles after rst returns high. Separately: rst while ch0 is debounced-pressed -> btn_level=0 with no release_pulse.
6. With DEBOUNCE_LONG_PRESS_EN: hold ch1 -> long_pulse[1] once, 20 cycles after press_pulse[1], never repeated while held; release at 15 cycles -> none. Without the macro: long_pulse==0 throughout.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the push-button debouncer family.
// Optional long-press support is enabled by defining DEBOUNCE_LONG_PRESS_EN.
package debounce_pkg;

   localparam int DEF_CNT_W    = 21;
   localparam int DEF_LONG_CNT = 50000000;

   // Raw level of a released button: pull-up buttons idle high.
   function automatic logic idle_level(input int active_low);
      return (active_low != 0);
   endfunction

   function automatic int settle_cycles(input int cnt_w);
      return 1 << (cnt_w - 1);
   endfunction

   // Counter width whose MSB first sets after the given settle time.
   function automatic int settle_cnt_w(input int settle);
      return $clog2(settle) + 1;
   endfunction

   function automatic int hold_w(input int long_cnt);
      return (long_cnt < 1) ? 1 : $clog2(long_cnt + 1);
   endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debouncer channel: synchroniser, settle counter, level and edge pulses.
// Hold counter and long_pulse exist only when DEBOUNCE_LONG_PRESS_EN is defined.
module debounce_chan
   import debounce_pkg::*;
#(
   parameter int CNT_W      = DEF_CNT_W,
   parameter int ACTIVE_LOW = 1,
   parameter int LONG_CNT   = DEF_LONG_CNT
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic level,
   output logic level_next,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse
);

   localparam logic             IDLE    = idle_level(ACTIVE_LOW);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   if (CNT_W < 2 || LONG_CNT < 1) begin : g_bad_cfg
      $error("debounce_chan: CNT_W must be >= 2 and LONG_CNT >= 1");
   end

   logic             s1_q, s1_d, s2_q, s2_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             press_q, press_d, release_q, release_d;

   always_comb begin
      s1_d  = btn_raw;
      s2_d  = s1_q;
      cnt_d = cnt_q;
      if (s1_q != s2_q)
         cnt_d = '0;
      else if (!cnt_q[CNT_W-1])
         cnt_d = cnt_q + CNT_ONE;
      // XOR with the idle level turns the raw sample into 1 = pressed.
      level_d   = cnt_q[CNT_W-1] ? (s2_q ^ IDLE) : level_q;
      press_d   = level_d & ~level_q;
      release_d = ~level_d & level_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_q      <= IDLE;
         s2_q      <= IDLE;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign level         = level_q;
   assign level_next    = level_d;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;

`ifdef DEBOUNCE_LONG_PRESS_EN
   localparam int           HW       = hold_w(LONG_CNT);
   localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CNT);
   localparam logic [HW-1:0] HOLD_ONE = HW'(1);

   logic [HW-1:0] hold_q, hold_d;
   logic          long_q, long_d;

   // Saturating at LONG_CNT makes the pulse fire once per press.
   always_comb begin
      hold_d = hold_q;
      long_d = 1'b0;
      if (!level_q) begin
         hold_d = '0;
      end else if (hold_q != HOLD_MAX) begin
         hold_d = hold_q + HOLD_ONE;
         long_d = (hold_d == HOLD_MAX);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         hold_q <= '0;
         long_q <= 1'b0;
      end else begin
         hold_q <= hold_d;
         long_q <= long_d;
      end
   end

   assign long_pulse = long_q;
`else
   assign long_pulse = 1'b0;
`endif

endmodule

// File: rtl/multi_debouncer.sv
// N-channel push-button debouncer with press/release pulses and any_pressed.
// Define DEBOUNCE_LONG_PRESS_EN to build per-channel long-press detection.
module multi_debouncer
   import debounce_pkg::*;
#(
   parameter int CHANNELS   = 4,
   parameter int CNT_W      = DEF_CNT_W,
   parameter int ACTIVE_LOW = 1,
   parameter int LONG_CNT   = DEF_LONG_CNT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] btn_in,
   output logic [CHANNELS-1:0] btn_level,
   output logic [CHANNELS-1:0] press_pulse,
   output logic [CHANNELS-1:0] release_pulse,
   output logic                any_pressed,
   output logic [CHANNELS-1:0] long_pulse
);

   if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_cfg
      $error("multi_debouncer: CHANNELS must be in 1..32");
   end

   logic [CHANNELS-1:0] level_next;
   logic                any_q, any_d;

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      debounce_chan #(
         .CNT_W      (CNT_W),
         .ACTIVE_LOW (ACTIVE_LOW),
         .LONG_CNT   (LONG_CNT)
      ) u_chan (
         .clk           (clk),
         .rst           (rst),
         .btn_raw       (btn_in[gi]),
         .level         (btn_level[gi]),
         .level_next    (level_next[gi]),
         .press_pulse   (press_pulse[gi]),
         .release_pulse (release_pulse[gi]),
         .long_pulse    (long_pulse[gi])
      );
   end

   // Built from the next-level vector so it lines up with btn_level.
   always_comb begin
      any_d = |level_next;
   end

   always_ff @(posedge clk) begin
      if (!rst)
         any_q <= 1'b0;
      else
         any_q <= any_d;
   end

   assign any_pressed = any_q;

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed bench for multi_debouncer (CHANNELS=4, CNT_W=4, ACTIVE_LOW=1, LONG_CNT=20).
// Long-press expectations follow DEBOUNCE_LONG_PRESS_EN.
module tb_multi_debouncer;

   localparam int CH = 4;
   localparam int CW = 4;
   localparam int LC = 20;
`ifdef DEBOUNCE_LONG_PRESS_EN
   localparam bit LONG_EN = 1'b1;
`else
   localparam bit LONG_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [CH-1:0] btn_in = 4'hF;
   logic [CH-1:0] btn_level, press_pulse, release_pulse, long_pulse;
   logic          any_pressed;

   int errors = 0;
   int checks = 0;
   int press_cnt[CH];
   int rel_cnt[CH];
   int long_cnt[CH];

   multi_debouncer #(
      .CHANNELS   (CH),
      .CNT_W      (CW),
      .ACTIVE_LOW (1),
      .LONG_CNT   (LC)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .btn_in        (btn_in),
      .btn_level     (btn_level),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .any_pressed   (any_pressed),
      .long_pulse    (long_pulse)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   // Advance one edge, sample 1 ns later and tally pulses.
   task automatic tick();
      @(posedge clk);
      #1;
      for (int i = 0; i < CH; i++) begin
         press_cnt[i] += int'(press_pulse[i]);
         rel_cnt[i]   += int'(release_pulse[i]);
         long_cnt[i]  += int'(long_pulse[i]);
      end
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic clear_counts();
      for (int i = 0; i < CH; i++) begin
         press_cnt[i] = 0;
         rel_cnt[i]   = 0;
         long_cnt[i]  = 0;
      end
   endtask

   initial begin
      clear_counts();
      // 1: reset, then idle inputs for 50 cycles
      ticks(3);
      check("rst_level", 32'(btn_level), 32'h0);
      check("rst_press", 32'(press_pulse), 32'h0);
      check("rst_any", 32'(any_pressed), 32'h0);
      rst = 1'b1;
      ticks(50);
      check("idle_level", 32'(btn_level), 32'h0);
      check("idle_pulses", 32'(press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3]
                              + rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3]), 32'h0);
      check("idle_long", 32'(long_cnt[0] + long_cnt[1] + long_cnt[2] + long_cnt[3]), 32'h0);

      // 2: clean press and release on ch0
      clear_counts();
      btn_in = 4'hE;
      ticks(10);
      check("p0_t10_level", 32'(btn_level), 32'h0);
      tick();
      check("p0_t11_level", 32'(btn_level), 32'h1);
      check("p0_t11_press", 32'(press_pulse), 32'h1);
      check("p0_t11_any", 32'(any_pressed), 32'h1);
      tick();
      check("p0_t12_press", 32'(press_pulse), 32'h0);
      ticks(30);
      check("p0_press_cnt", 32'(press_cnt[0]), 32'h1);
      btn_in = 4'hF;
      ticks(10);
      check("r0_t10_level", 32'(btn_level), 32'h1);
      tick();
      check("r0_t11_rel", 32'(release_pulse), 32'h1);
      check("r0_t11_level", 32'(btn_level), 32'h0);
      check("r0_t11_any", 32'(any_pressed), 32'h0);
      tick();
      check("r0_t12_rel", 32'(release_pulse), 32'h0);

      // 3: bouncing ch1, then 1-cycle glitch on ch2
      clear_counts();
      for (int i = 0; i < 8; i++) begin
         btn_in[1] = ~btn_in[1];
         ticks(5);
      end
      check("b1_no_press", 32'(press_cnt[1]), 32'h0);
      check("b1_level", 32'(btn_level), 32'h0);
      btn_in[1] = 1'b0;
      ticks(10);
      check("b1_t10_press", 32'(press_pulse), 32'h0);
      tick();
      check("b1_t11_press", 32'(press_pulse), 32'h2);
      btn_in[2] = 1'b0;
      tick();
      btn_in[2] = 1'b1;
      ticks(15);
      check("g2_press_cnt", 32'(press_cnt[2]), 32'h0);
      check("g2_level", 32'(btn_level), 32'h2);

      // 4: simultaneous press ch2+ch3, release ch2 only
      clear_counts();
      btn_in = 4'b0001;
      ticks(11);
      check("s23_press", 32'(press_pulse), 32'hC);
      btn_in = 4'b0101;
      ticks(11);
      check("s2_release", 32'(release_pulse), 32'h4);
      check("s2_level", 32'(btn_level), 32'hA);
      check("s2_any", 32'(any_pressed), 32'h1);
      btn_in = 4'hF;
      ticks(12);
      check("s_all_released", 32'(btn_level), 32'h0);

      // 5: reset at settle count 5, then reset while pressed
      btn_in = 4'hE;
      ticks(7);
      rst = 1'b0;
      tick();
      check("rs_mid_level", 32'(btn_level), 32'h0);
      check("rs_mid_press", 32'(press_pulse), 32'h0);
      clear_counts();
      rst = 1'b1;
      ticks(10);
      check("rs_t10_level", 32'(btn_level), 32'h0);
      tick();
      check("rs_t11_press", 32'(press_pulse), 32'h1);
      clear_counts();
      rst = 1'b0;
      tick();
      check("rp_level", 32'(btn_level), 32'h0);
      check("rp_release", 32'(release_pulse), 32'h0);
      rst = 1'b1;
      ticks(11);
      check("rp_repress", 32'(press_pulse), 32'h1);
      check("rp_rel_cnt", 32'(rel_cnt[0]), 32'h0);
      btn_in = 4'hF;
      ticks(12);

      // 6: long press on ch1, then short hold
      clear_counts();
      btn_in = 4'hD;
      ticks(11);
      check("l1_press", 32'(press_pulse), 32'h2);
      ticks(19);
      check("l1_t19_long", 32'(long_pulse), 32'h0);
      tick();
      check("l1_t20_long", 32'(long_pulse), LONG_EN ? 32'h2 : 32'h0);
      ticks(30);
      check("l1_long_cnt", 32'(long_cnt[1]), LONG_EN ? 32'h1 : 32'h0);
      btn_in = 4'hF;
      ticks(12);
      clear_counts();
      btn_in = 4'hD;
      ticks(11);
      check("l1s_press", 32'(press_pulse), 32'h2);
      ticks(4);
      btn_in = 4'hF;
      ticks(20);
      check("l1s_long_cnt", 32'(long_cnt[1]), 32'h0);
      check("l1s_level", 32'(btn_level), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
